irq_ctrl: RTL and testbench

//  Consumer end of the GPU/peripheral interrupt lines: the system interrupt controller (I_STAT/I_MASK).

---
 rtl/irq_ctrl.sv | 96 +++++++++
 tb/tb_irq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// System interrupt controller: latches rising edges of NUM_SRC level IRQ lines into sticky
// status bits, gates them with a mask and drives one registered CPU IRQ. Optional input sync: IRQ_CTRL_INPUT_SYNC_EN.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_regSel,
    input  logic               i_write,
    input  logic               i_read,
    input  logic [15:0]        i_wdata,
    output logic [15:0]        o_rdata,
    output logic               o_irq
);

    localparam int unsigned DW = 16;

    logic [NUM_SRC-1:0] stat_q, stat_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               irq_q, irq_d;
    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] wdata_src;
    logic [DW-1:0]      unused_wdata;

    // Upper write-data bits have no backing register.
    assign unused_wdata = i_wdata;
    assign wdata_src    = i_wdata[NUM_SRC-1:0];

`ifdef IRQ_CTRL_INPUT_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    assign sync1_d = i_src;
    assign sync2_d = sync1_q;
    assign src_s   = sync2_q;

    // Sync chain tracks i_src during reset so release never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= i_src;
            sync2_q <= i_src;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    assign src_s = i_src;
`endif

    always_comb begin
        prev_d   = src_s;
        src_edge = src_s & ~prev_q;
        stat_d   = stat_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        irq_d    = |(stat_q & mask_q);

        if (i_write && !i_regSel) begin
            stat_d = stat_q & wdata_src;
        end
        if (i_write && i_regSel) begin
            mask_d = wdata_src;
        end
        // New edge overrides a same-cycle acknowledge.
        stat_d = stat_d | src_edge;

        if (i_read) begin
            rdata_d = i_regSel ? DW'(mask_q) : DW'(stat_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            prev_q  <= i_src;
        end else begin
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            prev_q  <= prev_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_irq   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboarded random/directed bench for irq_ctrl; the reference model is a cycle-level
// description of the status/mask rules with a delay queue standing in for optional input sync.
module tb_irq_ctrl;

    localparam int unsigned NUM_SRC = 11;
    localparam int unsigned ALL     = (1 << NUM_SRC) - 1;
`ifdef IRQ_CTRL_INPUT_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic               clk = 1'b0;
    logic               i_rst;
    logic [NUM_SRC-1:0] i_src;
    logic               i_regSel;
    logic               i_write;
    logic               i_read;
    logic [15:0]        i_wdata;
    logic [15:0]        o_rdata;
    logic               o_irq;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_src   (i_src),
        .i_regSel(i_regSel),
        .i_write (i_write),
        .i_read  (i_read),
        .i_wdata (i_wdata),
        .o_rdata (o_rdata),
        .o_irq   (o_irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic        exp_irq_q[$];
    logic [15:0] exp_rd_q[$];

    // Reference model state
    int unsigned m_stat = 0, m_mask = 0, m_prev = 0;
    bit          m_irq = 0;
    logic [15:0] m_rdata = '0;
    int unsigned pipe[$];
    int unsigned cur_src = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of stimulus, advance the model, queue expected outputs.
    task automatic cycle(input bit rst, input int unsigned src, input bit sel,
                         input bit wr, input bit rd, input int unsigned wdata);
        int unsigned seen, edges;
        bit          nirq;
        i_rst    = rst;
        i_src    = NUM_SRC'(src);
        i_regSel = sel;
        i_write  = wr;
        i_read   = rd;
        i_wdata  = 16'(wdata);
        cur_src  = src & ALL;
        if (rst) begin
            m_stat = 0; m_mask = 0; m_irq = 0; m_rdata = '0;
            pipe.delete();
            for (int i = 0; i < int'(LAT); i++) pipe.push_back(src & ALL);
            m_prev = src & ALL;
        end else begin
            pipe.push_back(src & ALL);
            seen   = pipe.pop_front();
            edges  = seen & ~m_prev & ALL;
            m_prev = seen;
            nirq   = (m_stat & m_mask) != 0;
            if (rd) m_rdata = 16'(sel ? m_mask : m_stat);
            if (wr && !sel) m_stat = m_stat & wdata;
            if (wr && sel)  m_mask = wdata & ALL;
            m_stat = (m_stat | edges) & ALL;
            m_irq  = nirq;
        end
        exp_irq_q.push_back(m_irq);
        if (rd) exp_rd_q.push_back(m_rdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, cur_src, 0, 0, 0, 0);
    endtask

    task automatic rd_reg(input bit sel);
        cycle(0, cur_src, sel, 0, 1, 0);
    endtask

    // Monitor: every edge yields an irq sample; reads yield a data sample.
    bit          mon_rd;
    logic        e_irq;
    logic [15:0] e_rd;
    always @(posedge clk) begin
        mon_rd = i_read;
        #1;
        if (exp_irq_q.size() > 0) begin
            e_irq = exp_irq_q.pop_front();
            chk("o_irq", 32'(o_irq), 32'(e_irq));
        end
        if (mon_rd) begin
            if (exp_rd_q.size() == 0) begin
                chk("rdata_unexpected", 1, 0);
            end else begin
                e_rd = exp_rd_q.pop_front();
                chk("o_rdata", 32'(o_rdata), 32'(e_rd));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned flip, wd;
        bit          sel, wr, rd, rst;

        repeat (3) cycle(1, 0, 0, 0, 1, 0);

        // Mask GPU, pulse src[1] for three cycles
        cycle(0, 0, 1, 1, 0, 'h002);
        repeat (3) cycle(0, 'h002, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        idle(3);
        rd_reg(0);

        // Acknowledge bit 1
        cycle(0, 0, 0, 1, 0, 'hFFFD);
        idle(2);
        rd_reg(0);

        // Re-set bit 1, then ack coincident with a new rise
        cycle(0, 'h002, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        idle(2);
        cycle(0, 'h002, 0, 1, 1, 'hFFFD);
        idle(3);
        rd_reg(0);
        cycle(0, 'h002, 0, 1, 0, 'hFFFD);
        idle(2);
        rd_reg(0);

        // Masked source still latches; mask enable raises irq
        cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 'h001, 0, 0, 0, 0);
        idle(3);
        rd_reg(0);
        cycle(0, 'h001, 1, 1, 0, 'h001);
        idle(2);

        // Sources held high across reset release
        repeat (2) cycle(1, 'h7FF, 0, 0, 0, 0);
        idle(4);
        rd_reg(0);
        cycle(0, 'h7F7, 0, 0, 0, 0);
        cycle(0, 'h7FF, 0, 0, 0, 0);
        idle(3);
        rd_reg(0);

        // Writing ones never sets; mask reads are clipped
        cycle(0, 'h7FF, 0, 1, 0, 0);
        cycle(0, 'h7FF, 0, 1, 0, 'hFFFF);
        rd_reg(0);
        cycle(0, 'h7FF, 1, 1, 0, 'hFFFF);
        rd_reg(1);
        cycle(0, 'h7FF, 1, 1, 1, 'h0000);
        rd_reg(1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            flip = 0;
            for (int b = 0; b < int'(NUM_SRC); b++)
                if ($urandom_range(0, 5) == 0) flip |= (1 << b);
            sel = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       wd = ~(32'd1 << $urandom_range(0, 15));
                1:       wd = 'hFFFF;
                2:       wd = 0;
                default: wd = $urandom;
            endcase
            cycle(rst, cur_src ^ flip, sel, wr, rd, wd & 'hFFFF);
        end

        idle(4);
        #3;
        chk("scoreboard_drained", 32'(exp_irq_q.size() + exp_rd_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
